sram_march_bist: RTL and testbench

- Parametrised successor to the lab SRAM built-in self-test engine.
- Sweeps an external single-port SRAM (fixed read latency) with one of three selectable algorithms: address-in-data, March C- solid background, March C- checkerboard.
- Reports a sticky mismatch, the first failing address and a saturating failure count.
- Sits between the top-level start push-button/switch logic and the SRAM controller mux, in place of the original fixed-pattern BIST.

---
 rtl/sram_march_bist_pkg.sv | 61 ++++++
 rtl/sram_march_bist_if.sv | 24 ++
 rtl/sram_march_bist_compare_pipe.sv | 75 +++++++
 rtl/sram_march_bist.sv | 152 +++++++++++++++
 tb/tb_sram_march_bist.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_march_bist_pkg.sv
// Shared types and helpers for the SRAM march BIST: test modes, FSM states,
// the March C- element table and the data-background generator.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        MODE_ADDR    = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_RSVD    = 2'd3
    } bist_mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } bist_state_t;

    typedef struct packed {
        logic down;
        logic has_read;
        logic read_val;
        logic has_write;
        logic write_val;
    } march_elem_t;

    localparam logic [2:0] ELEM_FIRST = 3'd0;
    localparam logic [2:0] ELEM_LAST  = 3'd5;
    localparam int         BG_W       = 64;

    // March C-: up w0; up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up r0.
    // The address-in-data mode reuses entries 0 (write sweep) and 5 (read sweep).
    function automatic march_elem_t march_elem(input logic [2:0] idx);
        march_elem_t e;
        case (idx)
            3'd1:    e = march_elem_t'{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            3'd2:    e = march_elem_t'{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
            3'd3:    e = march_elem_t'{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            3'd4:    e = march_elem_t'{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            3'd5:    e = march_elem_t'{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            default: e = march_elem_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        endcase
        return e;
    endfunction

    function automatic logic elem_down(input logic [2:0] idx);
        march_elem_t e;
        e = march_elem(idx);
        return e.down;
    endfunction

    // Data background "D0"; callers truncate to their data width.
    function automatic logic [BG_W-1:0] bg_pattern(input logic addr_lsb, input bist_mode_t mode);
        logic [BG_W-1:0] bg;
        bg = '0;
        if (mode == MODE_CHECKER) begin
            bg = addr_lsb ? {(BG_W/2){2'b10}} : {(BG_W/2){2'b01}};
        end
        return bg;
    endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// Single-port SRAM bus between the BIST engine (master) and the SRAM mux (slave).
interface sram_march_bist_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] BIST_address;
    logic [DATA_W-1:0] BIST_write_data;
    logic              BIST_we_n;
    logic [DATA_W-1:0] BIST_read_data;

    modport master (
        output BIST_address,
        output BIST_write_data,
        output BIST_we_n,
        input  BIST_read_data
    );

    modport slave (
        input  BIST_address,
        input  BIST_write_data,
        input  BIST_we_n,
        output BIST_read_data
    );
endinterface

// File: rtl/sram_march_bist_compare_pipe.sv
// Delays each issued read by READ_LAT cycles, compares it with the returned
// SRAM data and accumulates sticky mismatch, first failing address and fail count.
module bist_compare_pipe #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_expected,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_read_data,
    output logic              o_mismatch,
    output logic [ADDR_W-1:0] o_fail_address,
    output logic [CNT_W-1:0]  o_fail_count
);

    logic [READ_LAT-1:0] r_valid;
    logic [DATA_W-1:0]   r_expected [READ_LAT];
    logic [ADDR_W-1:0]   r_addr     [READ_LAT];
    logic                r_mismatch;
    logic [ADDR_W-1:0]   r_fail_address;
    logic [CNT_W-1:0]    r_fail_count;
    logic                w_fail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_expected[i] <= '0;
                r_addr[i]     <= '0;
            end
        end else begin
            r_valid[0]    <= i_push;
            r_expected[0] <= i_expected;
            r_addr[0]     <= i_addr;
            for (int i = 1; i < READ_LAT; i++) begin
                r_valid[i]    <= r_valid[i-1];
                r_expected[i] <= r_expected[i-1];
                r_addr[i]     <= r_addr[i-1];
            end
        end
    end

    // The oldest stage lines up with the cycle its read data is valid.
    assign w_fail = r_valid[READ_LAT-1] & (i_read_data != r_expected[READ_LAT-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch     <= 1'b0;
            r_fail_address <= '0;
            r_fail_count   <= '0;
        end else if (i_clear) begin
            r_mismatch     <= 1'b0;
            r_fail_address <= '0;
            r_fail_count   <= '0;
        end else if (w_fail) begin
            r_mismatch <= 1'b1;
            if (!r_mismatch) begin
                r_fail_address <= r_addr[READ_LAT-1];
            end
            if (r_fail_count != {CNT_W{1'b1}}) begin
                r_fail_count <= r_fail_count + 1'b1;
            end
        end
    end

    assign o_mismatch     = r_mismatch;
    assign o_fail_address = r_fail_address;
    assign o_fail_count   = r_fail_count;

endmodule

// File: rtl/sram_march_bist.sv
// SRAM built-in self-test: sweeps the SRAM with address-in-data or March C-
// (solid / checkerboard) and reports mismatch, first failing address and fail count.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int                ADDR_W    = 18,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
    parameter int                READ_LAT  = 2,
    parameter int                CNT_W     = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               BIST_start,
    input  logic [1:0]         BIST_mode,
    sram_march_bist_if.master  sram,
    output logic               BIST_busy,
    output logic               BIST_finish,
    output logic               BIST_mismatch,
    output logic [ADDR_W-1:0]  BIST_fail_address,
    output logic [CNT_W-1:0]   BIST_fail_count
);

    bist_state_t       r_state, w_state_next;
    logic [2:0]        r_elem, w_elem_next;
    logic              r_phase, w_phase_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [2:0]        r_drain, w_drain_next;
    bist_mode_t        r_mode, w_mode_next;
    logic              r_start_buf;

    march_elem_t       w_elem;
    logic [2:0]        w_next_idx;
    logic [DATA_W-1:0] w_bg;
    logic [DATA_W-1:0] w_data;
    logic              w_start;
    logic              w_is_read;
    logic              w_is_write;
    logic              w_addr_done;
    logic              w_at_end;
    logic              w_elem_final;
    logic              w_data_bit;

    assign w_elem       = march_elem(r_elem);
    assign w_start      = BIST_start & ~r_start_buf & (r_state == S_IDLE);
    assign w_is_read    = (r_state == S_RUN) & w_elem.has_read & ~r_phase;
    assign w_is_write   = (r_state == S_RUN) & w_elem.has_write & (~w_elem.has_read | r_phase);
    assign w_addr_done  = ~(w_elem.has_read & w_elem.has_write) | r_phase;
    // Equality-based terminal detect so LAST_ADDR = all-ones never needs a wrap.
    assign w_at_end     = w_elem.down ? (r_addr == '0) : (r_addr == LAST_ADDR);
    assign w_elem_final = (r_elem == ELEM_LAST);
    assign w_next_idx   = (r_mode == MODE_ADDR) ? ELEM_LAST : r_elem + 3'd1;
    assign w_bg         = DATA_W'(bg_pattern(r_addr[0], r_mode));
    assign w_data_bit   = w_is_read ? w_elem.read_val : w_elem.write_val;

    always_comb begin
        w_data = w_data_bit ? ~w_bg : w_bg;
        if (r_mode == MODE_ADDR) begin
            w_data = DATA_W'(r_addr);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_elem_next  = r_elem;
        w_phase_next = r_phase;
        w_addr_next  = r_addr;
        w_drain_next = r_drain;
        w_mode_next  = r_mode;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_RUN;
                    w_elem_next  = ELEM_FIRST;
                    w_phase_next = 1'b0;
                    w_addr_next  = '0;
                    w_drain_next = '0;
                    w_mode_next  = (BIST_mode == MODE_RSVD) ? MODE_SOLID : bist_mode_t'(BIST_mode);
                end
            end
            S_RUN: begin
                if (!w_addr_done) begin
                    w_phase_next = 1'b1;
                end else begin
                    w_phase_next = 1'b0;
                    if (!w_at_end) begin
                        w_addr_next = w_elem.down ? r_addr - 1'b1 : r_addr + 1'b1;
                    end else if (w_elem_final) begin
                        w_state_next = S_DRAIN;
                        w_drain_next = '0;
                    end else begin
                        w_elem_next = w_next_idx;
                        w_addr_next = elem_down(w_next_idx) ? LAST_ADDR : '0;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain == 3'(READ_LAT - 1)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_drain_next = r_drain + 3'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_elem      <= ELEM_FIRST;
            r_phase     <= 1'b0;
            r_addr      <= '0;
            r_drain     <= '0;
            r_mode      <= MODE_ADDR;
            r_start_buf <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_elem      <= w_elem_next;
            r_phase     <= w_phase_next;
            r_addr      <= w_addr_next;
            r_drain     <= w_drain_next;
            r_mode      <= w_mode_next;
            r_start_buf <= BIST_start;
        end
    end

    assign sram.BIST_address    = (r_state == S_IDLE) ? '0 : r_addr;
    assign sram.BIST_we_n       = ~w_is_write;
    assign sram.BIST_write_data = w_is_write ? w_data : '0;
    assign BIST_busy            = (r_state != S_IDLE);
    assign BIST_finish          = (r_state == S_IDLE);

    bist_compare_pipe #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT),
        .CNT_W    (CNT_W)
    ) u_compare (
        .clk            (Clock),
        .rst            (Reset),
        .i_clear        (w_start),
        .i_push         (w_is_read),
        .i_expected     (w_data),
        .i_addr         (r_addr),
        .i_read_data    (sram.BIST_read_data),
        .o_mismatch     (BIST_mismatch),
        .o_fail_address (BIST_fail_address),
        .o_fail_count   (BIST_fail_count)
    );

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two engines (16-bit and 2-bit fail counters) share
// stimulus, each with a fault-injecting SRAM model; results come from an op-list model.
module tb_sram_march_bist;
    import sram_bist_pkg::*;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int READ_LAT = 2;
    localparam int N        = 16;
    localparam int NDUT     = 2;
    localparam logic [ADDR_W-1:0] LAST = 4'hF;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;

    // fault kinds: 0 none, 1 stuck bit, 2 coupling (addr reads src), 3 all reads FFFF
    int   fault_kind, fault_addr, fault_bit, fault_src;
    logic fault_val;

    logic [NDUT-1:0]   busy_v, finish_v, mism_v, we_n_v;
    logic [ADDR_W-1:0] faddr_v [NDUT];
    logic [ADDR_W-1:0] addr_v  [NDUT];
    logic [15:0]       fcnt_v  [NDUT];
    logic [15:0]       wdata_v [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] sram_read(int a, logic [15:0] own, logic [15:0] src);
        logic [15:0] v;
        v = own;
        case (fault_kind)
            1: if (a == fault_addr) v[fault_bit] = fault_val;
            2: if (a == fault_addr) v = src;
            3: v = 16'hFFFF;
            default: v = own;
        endcase
        return v;
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int CW = (gi == 0) ? 16 : 2;
        sram_march_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
        logic [CW-1:0] cnt;
        logic [15:0]   mem     [N];
        logic [15:0]   rd_pipe [READ_LAT];

        sram_march_bist #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST),
            .READ_LAT(READ_LAT), .CNT_W(CW)
        ) u_dut (
            .Clock             (clk),
            .Reset             (rst),
            .BIST_start        (start),
            .BIST_mode         (mode),
            .sram              (bus),
            .BIST_busy         (busy_v[gi]),
            .BIST_finish       (finish_v[gi]),
            .BIST_mismatch     (mism_v[gi]),
            .BIST_fail_address (faddr_v[gi]),
            .BIST_fail_count   (cnt)
        );

        always @(posedge clk) begin
            if (!bus.BIST_we_n) mem[bus.BIST_address] <= bus.BIST_write_data;
            rd_pipe[0] <= sram_read(int'(bus.BIST_address), mem[bus.BIST_address],
                                    mem[fault_src[ADDR_W-1:0]]);
            for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end

        assign bus.BIST_read_data = rd_pipe[READ_LAT-1];
        assign fcnt_v[gi]  = 16'(cnt);
        assign addr_v[gi]  = bus.BIST_address;
        assign wdata_v[gi] = bus.BIST_write_data;
        assign we_n_v[gi]  = bus.BIST_we_n;
    end

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the op stream implied by the algorithm, replayed on a plain array.
    typedef struct {
        bit          wr;
        int          addr;
        logic [15:0] data;
    } op_t;

    op_t ops[$];
    int  exp_fails;
    int  exp_first;

    function automatic logic [15:0] bgv(int a, int m);
        if (m == 2) return (a % 2 == 0) ? 16'h5555 : 16'hAAAA;
        return 16'h0000;
    endfunction

    task automatic add_elem(bit down, int rv, int wv, int m);
        for (int k = 0; k < N; k++) begin
            int a;
            a = down ? N - 1 - k : k;
            if (rv >= 0) ops.push_back('{1'b0, a, (rv == 1) ? ~bgv(a, m) : bgv(a, m)});
            if (wv >= 0) ops.push_back('{1'b1, a, (wv == 1) ? ~bgv(a, m) : bgv(a, m)});
        end
    endtask

    task automatic build_ref(int m_in);
        int          m;
        logic [15:0] rm [N];
        logic [15:0] v;
        m = (m_in == 3) ? 1 : m_in;
        ops.delete();
        if (m == 0) begin
            for (int a = 0; a < N; a++) ops.push_back('{1'b1, a, 16'(a)});
            for (int a = 0; a < N; a++) ops.push_back('{1'b0, a, 16'(a)});
        end else begin
            add_elem(0, -1, 0, m);
            add_elem(0, 0, 1, m);
            add_elem(0, 1, 0, m);
            add_elem(1, 0, 1, m);
            add_elem(1, 1, 0, m);
            add_elem(0, 0, -1, m);
        end
        exp_fails = 0;
        exp_first = -1;
        foreach (ops[i]) begin
            if (ops[i].wr) begin
                rm[ops[i].addr] = ops[i].data;
            end else begin
                v = sram_read(ops[i].addr, rm[ops[i].addr], rm[fault_src]);
                if (v !== ops[i].data) begin
                    exp_fails++;
                    if (exp_first < 0) exp_first = ops[i].addr;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check_eq({tag, ":addr"},   32'(addr_v[0]),  0);
        check_eq({tag, ":we_n"},   32'(we_n_v[0]),  1);
        check_eq({tag, ":wdata"},  32'(wdata_v[0]), 0);
        check_eq({tag, ":busy"},   32'(busy_v[0]),  0);
        check_eq({tag, ":finish"}, 32'(finish_v[0]), 1);
        check_eq({tag, ":mism"},   32'(mism_v[0]),  0);
        check_eq({tag, ":faddr"},  32'(faddr_v[0]), 0);
        check_eq({tag, ":fcnt"},   32'(fcnt_v[0]),  0);
        check_eq({tag, ":fcnt2"},  32'(fcnt_v[1]),  0);
    endtask

    task automatic set_fault(int fk, int fa, int fb, int fv, int fs);
        fault_kind = fk;
        fault_addr = fa;
        fault_bit  = fb;
        fault_val  = fv[0];
        fault_src  = fs;
    endtask

    task automatic run_one(string name, int m, bit poke);
        int nops;
        int j;
        bit done;
        int sat;
        build_ref(m);
        nops = ops.size();
        @(negedge clk);
        mode  = 2'(m);
        start = 1'b1;
        @(posedge clk);
        j    = 0;
        done = 0;
        while (!done && j < nops + READ_LAT + 20) begin
            @(negedge clk);
            if (j == 0) begin
                start = 1'b0;
                check_eq({name, ":busy"}, 32'(busy_v[0]), 1);
            end
            if (poke && j == 5) start = 1'b1;
            if (poke && j == 7) start = 1'b0;
            if (j < nops) begin
                check_eq({name, ":we_n"}, 32'(we_n_v[0]), 32'(!ops[j].wr));
                check_eq({name, ":addr"}, 32'(addr_v[0]), 32'(ops[j].addr));
                if (ops[j].wr) check_eq({name, ":wdata"}, 32'(wdata_v[0]), 32'(ops[j].data));
            end else if (!finish_v[0]) begin
                check_eq({name, ":drain_we_n"}, 32'(we_n_v[0]), 1);
            end
            if (finish_v[0] && finish_v[1]) done = 1;
            else j++;
        end
        check_eq({name, ":done"}, 32'(done), 1);
        check_eq({name, ":cycles"}, 32'(j), 32'(nops + READ_LAT));
        sat = (exp_fails > 3) ? 3 : exp_fails;
        check_eq({name, ":mism"},   32'(mism_v[0]),  32'(exp_fails > 0));
        check_eq({name, ":faddr"},  32'(faddr_v[0]), (exp_fails > 0) ? 32'(exp_first) : 0);
        check_eq({name, ":fcnt"},   32'(fcnt_v[0]),  32'(exp_fails));
        check_eq({name, ":mism2"},  32'(mism_v[1]),  32'(exp_fails > 0));
        check_eq({name, ":faddr2"}, 32'(faddr_v[1]), (exp_fails > 0) ? 32'(exp_first) : 0);
        check_eq({name, ":fcnt2"},  32'(fcnt_v[1]),  32'(sat));
        $display("run %s mode=%0d fault=%0d ops=%0d fails=%0d first=%0d cycles=%0d",
                 name, m, fault_kind, nops, exp_fails, exp_first, j);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        set_fault(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        run_one("addr_data", 0, 0);
        run_one("solid", 1, 1);
        set_fault(1, 7, 3, 1, 0);
        run_one("stuck7b3", 1, 0);
        check_eq("stuck7b3:plan_cnt", 32'(fcnt_v[0]), 3);
        set_fault(2, 9, 0, 0, 8);
        run_one("couple9_8", 2, 0);
        check_eq("couple9_8:plan_faddr", 32'(faddr_v[0]), 9);
        set_fault(3, 0, 0, 0, 0);
        run_one("all_ones", 3, 0);
        check_eq("all_ones:sat", 32'(fcnt_v[1]), 3);

        // Reset mid-run after failures have already been recorded.
        set_fault(1, 0, 0, 1, 0);
        @(negedge clk);
        mode  = 2'd1;
        start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (j == 0) start = 1'b0;
        end
        check_eq("midrun:mism", 32'(mism_v[0]), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_fault(0, 0, 0, 0, 0);
        run_one("after_rst", 1, 0);

        for (int r = 0; r < 8; r++) begin
            int fa;
            fa = int'($urandom_range(0, N - 1));
            set_fault(int'($urandom_range(0, 3)), fa, int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 1)), (fa + 1 + int'($urandom_range(0, N - 2))) % N);
            run_one($sformatf("rand%0d", r), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
